// File: rtl/xyolo_databus_responder.sv
// Single-outstanding databus responder backed by a word-addressed, byte-writable memory.
// Programmable ready latency, read/write counters and a sticky protocol-error flag.
module xyolo_databus_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  databus_valid,
    input  logic [ADDR_W-1:0]     databus_addr,
    input  logic [DATA_W-1:0]     databus_wdata,
    input  logic [DATA_W/8-1:0]   databus_wstrb,
    output logic                  databus_ready,
    output logic [DATA_W-1:0]     databus_rdata,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count,
    output logic                  protocol_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [ADDR_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [LANES-1:0]        wstrb_reg;
    logic                    capture;
    logic                    rd_en;
    logic [MEM_ADDR_W-1:0]   rd_idx;
    logic [MEM_ADDR_W-1:0]   cap_idx;
    logic [MEM_ADDR_W-1:0]   in_idx;
    logic                    mem_we;
    logic                    req_mismatch;
    logic [DATA_W-1:0]       rd_word_reg;
    logic [DATA_W-1:0]       mem [DEPTH];

    assign cap_idx = addr_reg[OFF_W +: MEM_ADDR_W];
    assign in_idx  = databus_addr[OFF_W +: MEM_ADDR_W];

    assign req_mismatch = !databus_valid
                        || (databus_addr  != addr_reg)
                        || (databus_wdata != wdata_reg)
                        || (databus_wstrb != wstrb_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = cap_idx;
        case (state_reg)
            IDLE: begin
                if (databus_valid) begin
                    capture  = 1'b1;
                    cnt_next = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // No WAIT cycle: issue the read from the live address now.
                        state_next = RESP;
                        rd_en      = 1'b1;
                        rd_idx     = in_idx;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    rd_en      = 1'b1;
                end else begin
                    cnt_next = 4'(cnt_reg - 4'd1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            rd_count     <= '0;
            wr_count     <= '0;
            protocol_err <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                addr_reg  <= databus_addr;
                wdata_reg <= databus_wdata;
                wstrb_reg <= databus_wstrb;
            end
            if ((state_reg == WAIT || state_reg == RESP) && req_mismatch) begin
                protocol_err <= 1'b1;
            end
            if (state_reg == RESP) begin
                if (wstrb_reg == '0) begin
                    rd_count <= rd_count + 1'b1;
                end else begin
                    wr_count <= wr_count + 1'b1;
                end
            end
        end
    end

    // Gated by rst so a reset coinciding with the RESP edge still aborts the write.
    assign mem_we = (state_reg == RESP) && (wstrb_reg != '0) && !rst;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_word_reg <= mem[rd_idx];
        end
        if (mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (wstrb_reg[b]) begin
                    mem[cap_idx][b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
            end
        end
    end

    assign databus_ready = (state_reg == RESP);
    assign databus_rdata = (state_reg == RESP && wstrb_reg == '0) ? rd_word_reg : '0;

endmodule

// File: tb/tb_xyolo_databus_responder.sv
// Randomized bench for the databus responder: two instances (LATENCY 3 and 1) each driven
// against a transaction-level memory/timing model and checked every cycle.
module tb_xyolo_databus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    bit  done_v [2];

    task automatic check(input int lat, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL L%0d %s: got %0h expected %0h at %0t", lat, name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 3 : 1;

        logic        rst, valid, ready, perr;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb, rdc, wrc;

        logic [31:0] mdl [1024];
        int          n_rd, n_wr;
        logic        exp_ready, exp_err;
        logic [31:0] exp_rdata, last_rdata;

        xyolo_databus_responder #(
            .DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .LATENCY(LAT), .CNT_W(4)
        ) dut (
            .clk(clk), .rst(rst),
            .databus_valid(valid), .databus_addr(addr),
            .databus_wdata(wdata), .databus_wstrb(wstrb),
            .databus_ready(ready), .databus_rdata(rdata),
            .rd_count(rdc), .wr_count(wrc), .protocol_err(perr)
        );

        always @(negedge clk) begin
            check(LAT, "ready", 64'(ready), 64'(exp_ready));
            check(LAT, "rdata", 64'(rdata), 64'(exp_rdata));
            check(LAT, "rd_count", 64'(rdc), 64'(n_rd % 16));
            check(LAT, "wr_count", 64'(wrc), 64'(n_wr % 16));
            check(LAT, "protocol_err", 64'(perr), 64'(exp_err));
            if (ready) last_rdata = rdata;
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        // mode 0: clean, 1: perturb addr for one cycle, 2: drop valid early
        task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int gap);
            logic [31:0] old, merged;
            logic        pend;
            int          idx;
            valid = 1'b0;
            repeat (gap) step();
            idx  = int'(a[11:2]);
            old  = mdl[idx];
            pend = 1'b0;
            valid = 1'b1; addr = a; wdata = d; wstrb = s;
            for (int k = 1; k <= LAT; k++) begin
                step();
                if (pend) exp_err = 1'b1;
                exp_ready = (k == LAT);
                exp_rdata = (k == LAT && s == 4'd0) ? old : 32'd0;
                if (k == 1 && mode == 1) begin addr = a ^ 32'h0000_0040; pend = 1'b1; end
                if (k == 1 && mode == 2) begin valid = 1'b0; pend = 1'b1; end
                if (k == 2) addr = a;
            end
            step();
            if (pend) exp_err = 1'b1;
            exp_ready = 1'b0;
            exp_rdata = 32'd0;
            if (s == 4'd0) begin
                n_rd++;
            end else begin
                n_wr++;
                merged = old;
                for (int b = 0; b < 4; b++) if (s[b]) merged[b*8 +: 8] = d[b*8 +: 8];
                mdl[idx] = merged;
            end
            valid = 1'b0;
            addr  = a;
        endtask

        function automatic logic [31:0] rand_addr();
            logic [31:0] r;
            r = $urandom();
            return (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
        endfunction

        task automatic rand_txn(input bit allow_err);
            logic [3:0] s;
            int         mode;
            s    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mode = (allow_err && $urandom_range(0, 7) == 0) ? $urandom_range(1, (LAT > 1) ? 2 : 1) : 0;
            txn(rand_addr(), $urandom(), s, mode, $urandom_range(0, 2));
        endtask

        initial begin
            rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
            exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0; n_rd = 0; n_wr = 0;
            repeat (3) step();
            rst = 1'b0;
            step();

            txn(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
            txn(32'h10, 32'h0, 4'h0, 0, 1);
            check(LAT, "raw_rdata", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
            check(LAT, "raw_rd_count", 64'(rdc), 64'd1);
            check(LAT, "raw_wr_count", 64'(wrc), 64'd1);

            txn(32'h10, 32'h1122_3344, 4'hF, 0, 0);
            txn(32'h10, 32'hAABB_CCDD, 4'b0101, 0, 0);
            txn(32'h10, 32'h0, 4'h0, 0, 0);
            check(LAT, "strobe_rdata", 64'(last_rdata), 64'h0000_0000_11BB_33DD);

            txn(32'h1000, 32'h5, 4'hF, 0, 2);
            txn(32'h0, 32'h0, 4'h0, 0, 0);
            check(LAT, "alias_rdata", 64'(last_rdata), 64'h5);

            for (int i = 0; i < 16; i++) txn(32'(i * 4), $urandom(), 4'hF, 0, 0);
            repeat (60) rand_txn(1'b0);
            check(LAT, "err_clean", 64'(perr), 64'd0);

            txn(32'h20, 32'h0, 4'h0, 1, 0);
            check(LAT, "err_set", 64'(perr), 64'd1);
            repeat (40) rand_txn(1'b1);
            check(LAT, "err_sticky", 64'(perr), 64'd1);

            // Abort a write one cycle after capture.
            valid = 1'b1; addr = 32'h0C; wdata = ~mdl[3]; wstrb = 4'hF;
            step();
            rst = 1'b1; valid = 1'b0;
            exp_ready = 1'b0; exp_rdata = '0; exp_err = 1'b0; n_rd = 0; n_wr = 0;
            step();
            step();
            rst = 1'b0;
            step();
            check(LAT, "abort_rd_count", 64'(rdc), 64'd0);
            check(LAT, "abort_wr_count", 64'(wrc), 64'd0);
            check(LAT, "abort_err", 64'(perr), 64'd0);
            txn(32'h0C, 32'h0, 4'h0, 0, 0);

            repeat (17) txn(rand_addr(), 32'h0, 4'h0, 0, 0);
            check(LAT, "rd_wrap", 64'(rdc), 64'd2);
            repeat (20) rand_txn(1'b0);

            done_v[gi] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done_v[0] && done_v[1]);
            begin
                #2_000_000;
                fails++;
                $display("FAIL watchdog: got timeout expected completion");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
